// File: rtl/core_ctrl_if.sv
`timescale 1ns/1ps
// core_ctrl_if
// Bundles the sequencer's handshake and strobe signals.
//   master : the sequencer (core_ctrl). It drives the fetch/data requests,
//            the datapath strobes and the status outputs.
//   slave  : the datapath/memory side. It drives start, the acks, the fetched
//            instruction and the EXE result.
// Signals:
//   start            leave IDLE and begin fetching
//   imem_req/ack     instruction fetch handshake; inst is valid with imem_ack
//   ir_we            instruction register load strobe
//   exe_result       EXE data_out (bit0 = branch condition)
//   dmem_req/we/ack  data access handshake (we: 1 = store)
//   rf_we, wb_sel    register-file writeback strobe and source select
//   pc_we, pc_sel    PC update strobe and source select
//   halted, illegal  stop status and its cause
//   instret          retired-instruction count
interface core_ctrl_if #(
  parameter int IW = 32,
  parameter int DW = 32
);
  logic          start;
  logic          imem_req;
  logic          imem_ack;
  logic [IW-1:0] inst;
  logic          ir_we;
  logic [DW-1:0] exe_result;
  logic          dmem_req;
  logic          dmem_we;
  logic          dmem_ack;
  logic          rf_we;
  logic [1:0]    wb_sel;
  logic          pc_we;
  logic [1:0]    pc_sel;
  logic          halted;
  logic          illegal;
  logic [31:0]   instret;

  modport master (
    input  start, imem_ack, inst, exe_result, dmem_ack,
    output imem_req, ir_we, dmem_req, dmem_we, rf_we, wb_sel,
           pc_we, pc_sel, halted, illegal, instret
  );

  modport slave (
    output start, imem_ack, inst, exe_result, dmem_ack,
    input  imem_req, ir_we, dmem_req, dmem_we, rf_we, wb_sel,
           pc_we, pc_sel, halted, illegal, instret
  );
endinterface

// File: rtl/core_ctrl.sv
`timescale 1ns/1ps
// core_ctrl
// Multi-cycle sequencer for the single-issue RV32I core. Steps each
// instruction through FETCH, DECODE, EXECUTE, optional MEM and WB, drives the
// PC / IR / register-file strobes and the memory handshakes, halts on SYSTEM
// or illegal encodings and counts retired instructions.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  core_ctrl_if.master (handshakes, strobes, status, instret)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start, all strobes low
// FETCH    | imem_req held until imem_ack; IR loads on the ack cycle
// DECODE   | register-file read; legality check of the latched IR
// EXECUTE  | exe_result valid; branches resolve and retire here
// MEM      | dmem_req held until dmem_ack; stores retire on the ack
// WB       | register-file write (unless rd = x0), PC update, retire
// HALT     | stopped; only rst leaves this state
module core_ctrl #(
  parameter int IW = 32,
  parameter int DW = 32
) (
  input  logic        clk,
  input  logic        rst,
  core_ctrl_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_EXECUTE = 3'd3;
  localparam logic [2:0] S_MEM     = 3'd4;
  localparam logic [2:0] S_WB      = 3'd5;
  localparam logic [2:0] S_HALT    = 3'd6;

  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  localparam logic [1:0] WB_EXE  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  localparam logic [1:0] PC_PC4  = 2'd0;
  localparam logic [1:0] PC_BR   = 2'd1;
  localparam logic [1:0] PC_JUMP = 2'd2;

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] ir_q;
  logic [31:0]   instret_q;
  logic          illegal_q;

  logic [4:0] opc;
  logic       is_load, is_store, is_branch, is_jump, is_system, is_legal;

  logic       imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we;
  logic [1:0] wb_sel, pc_sel;
  logic       retire, set_illegal;

  // Only the opcode, rd and the low two bits of IR matter to sequencing;
  // the upper EXE result bits only matter to the datapath.
  logic unused_bits;
  assign unused_bits = ^{ir_q[IW-1:12], bus.exe_result[DW-1:1]};

  always_comb begin
    opc       = ir_q[6:2];
    is_load   = (opc == OPC_LOAD);
    is_store  = (opc == OPC_STORE);
    is_branch = (opc == OPC_BRANCH);
    is_jump   = (opc == OPC_JAL) || (opc == OPC_JALR);
    is_system = (opc == OPC_SYSTEM);
    is_legal  = 1'b0;
    if (ir_q[1:0] == 2'b11) begin
      case (opc)
        OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
        OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM: is_legal = 1'b1;
        default: is_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    rf_we       = 1'b0;
    wb_sel      = WB_EXE;
    pc_we       = 1'b0;
    pc_sel      = PC_PC4;
    retire      = 1'b0;
    set_illegal = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FETCH;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (is_legal) begin
          state_d = S_EXECUTE;
        end else begin
          set_illegal = 1'b1;
          state_d     = S_HALT;
        end
      end

      S_EXECUTE: begin
        if (is_branch) begin
          pc_we   = 1'b1;
          pc_sel  = bus.exe_result[0] ? PC_BR : PC_PC4;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_system) begin
          state_d = S_HALT;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (bus.dmem_ack) begin
          if (is_store) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        rf_we   = (ir_q[11:7] != 5'd0);
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
        if (is_load) begin
          wb_sel = WB_LOAD;
        end else if (is_jump) begin
          wb_sel = WB_PC4;
          pc_sel = PC_JUMP;
        end
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ir_we)       ir_q      <= bus.inst;
      if (retire)      instret_q <= instret_q + 32'd1;
      if (set_illegal) illegal_q <= 1'b1;
    end
  end

  assign bus.imem_req = imem_req;
  assign bus.ir_we    = ir_we;
  assign bus.dmem_req = dmem_req;
  assign bus.dmem_we  = dmem_we;
  assign bus.rf_we    = rf_we;
  assign bus.wb_sel   = wb_sel;
  assign bus.pc_we    = pc_we;
  assign bus.pc_sel   = pc_sel;
  assign bus.halted   = (state_q == S_HALT);
  assign bus.illegal  = illegal_q;
  assign bus.instret  = instret_q;

endmodule

// File: tb/tb_core_ctrl.sv
`timescale 1ns/1ps
// tb_core_ctrl
// Directed-vector bench for core_ctrl. Inputs change 1 ns after a rising
// edge; outputs are sampled 1 ns later, well away from the next edge.
// Output vector layout used by the expected constants:
//   [11] imem_req [10] ir_we [9] dmem_req [8] dmem_we [7] rf_we
//   [6:5] wb_sel [4] pc_we [3:2] pc_sel [1] halted [0] illegal
module tb_core_ctrl;

  logic clk = 1'b0;
  logic rst;

  core_ctrl_if ifc ();

  core_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] O_NONE      = 12'h000;
  localparam logic [11:0] O_FETCH     = 12'h800;
  localparam logic [11:0] O_FETCH_ACK = 12'hC00;
  localparam logic [11:0] O_MEM_LD    = 12'h200;
  localparam logic [11:0] O_MEM_ST_AK = 12'h310;
  localparam logic [11:0] O_WB_ALU    = 12'h090;
  localparam logic [11:0] O_WB_X0     = 12'h010;
  localparam logic [11:0] O_WB_LOAD   = 12'h0B0;
  localparam logic [11:0] O_WB_JAL    = 12'h0D8;
  localparam logic [11:0] O_BR_T      = 12'h014;
  localparam logic [11:0] O_BR_N      = 12'h010;
  localparam logic [11:0] O_HALT_ILL  = 12'h003;
  localparam logic [11:0] O_HALT_SYS  = 12'h002;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] outs_now();
    return {ifc.imem_req, ifc.ir_we, ifc.dmem_req, ifc.dmem_we, ifc.rf_we,
            ifc.wb_sel, ifc.pc_we, ifc.pc_sel, ifc.halted, ifc.illegal};
  endfunction

  // Check this cycle's outputs, then advance one clock.
  task automatic cyc(input string tag, input logic [11:0] exp);
    #1;
    check_val(tag, {20'd0, outs_now()}, {20'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    ifc.start      = 1'b0;
    ifc.imem_ack   = 1'b0;
    ifc.dmem_ack   = 1'b0;
    ifc.inst       = '0;
    ifc.exe_result = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic start_pulse();
    ifc.start = 1'b1;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
  endtask

  // Called in FETCH: 'waits' cycles without ack, then the ack cycle.
  task automatic do_fetch(input string tag, input logic [31:0] word, input int waits);
    ifc.imem_ack = 1'b0;
    for (int i = 0; i < waits; i++) cyc({tag, "_fwait"}, O_FETCH);
    ifc.inst     = word;
    ifc.imem_ack = 1'b1;
    cyc({tag, "_fack"}, O_FETCH_ACK);
    ifc.imem_ack = 1'b0;
  endtask

  task automatic run_illegal(input string tag, input logic [31:0] word);
    do_reset();
    start_pulse();
    do_fetch(tag, word, 0);
    cyc({tag, "_dec"}, O_NONE);
    cyc({tag, "_halt"}, O_HALT_ILL);
    check_val({tag, "_instret"}, ifc.instret, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    #1;
    check_val("rst_outs", {20'd0, outs_now()}, 32'd0);
    check_val("rst_instret", ifc.instret, 32'd0);

    // start ignored until asserted: one idle cycle stays quiet
    cyc("idle", O_NONE);
    start_pulse();

    // addi x1,x0,5 : FETCH, DECODE, EXECUTE, WB
    ifc.exe_result = 32'd5;
    do_fetch("addi", 32'h0050_0093, 0);
    cyc("addi_dec", O_NONE);
    cyc("addi_exe", O_NONE);
    check_val("addi_pre_instret", ifc.instret, 32'd0);
    cyc("addi_wb", O_WB_ALU);
    check_val("addi_instret", ifc.instret, 32'd1);

    // lw x2,0(x1) with one imem wait and dmem_ack 3 cycles late
    do_fetch("lw", 32'h0000_A103, 1);
    cyc("lw_dec", O_NONE);
    cyc("lw_exe", O_NONE);
    ifc.imem_ack = 1'b1;               // stray imem ack outside FETCH
    cyc("lw_mem_w0", O_MEM_LD);
    ifc.imem_ack = 1'b0;
    cyc("lw_mem_w1", O_MEM_LD);
    cyc("lw_mem_w2", O_MEM_LD);
    ifc.dmem_ack = 1'b1;
    cyc("lw_mem_ack", O_MEM_LD);
    ifc.dmem_ack = 1'b0;
    cyc("lw_wb", O_WB_LOAD);
    check_val("lw_instret", ifc.instret, 32'd2);

    // beq taken, with a stray dmem ack during decode
    do_fetch("beq_t", 32'h0020_8463, 0);
    ifc.dmem_ack = 1'b1;
    cyc("beq_t_dec", O_NONE);
    ifc.dmem_ack   = 1'b0;
    ifc.exe_result = 32'd1;
    cyc("beq_t_exe", O_BR_T);
    check_val("beq_t_instret", ifc.instret, 32'd3);

    // beq not taken
    do_fetch("beq_n", 32'h0020_8463, 0);
    cyc("beq_n_dec", O_NONE);
    ifc.exe_result = 32'd0;
    cyc("beq_n_exe", O_BR_N);
    check_val("beq_n_instret", ifc.instret, 32'd4);

    // sw x2,0(x1), zero-wait data memory
    do_fetch("sw", 32'h0020_A023, 0);
    cyc("sw_dec", O_NONE);
    cyc("sw_exe", O_NONE);
    ifc.dmem_ack = 1'b1;
    cyc("sw_mem", O_MEM_ST_AK);
    ifc.dmem_ack = 1'b0;
    check_val("sw_instret", ifc.instret, 32'd5);
    #1;
    check_val("sw_next_fetch", {20'd0, outs_now()}, {20'd0, O_FETCH});

    // jal x1,8
    ifc.exe_result = 32'h0000_0101;
    do_fetch("jal", 32'h0080_00EF, 0);
    cyc("jal_dec", O_NONE);
    cyc("jal_exe", O_NONE);
    cyc("jal_wb", O_WB_JAL);
    check_val("jal_instret", ifc.instret, 32'd6);

    // all-zero word is illegal; start in HALT is ignored
    do_fetch("ill0", 32'h0000_0000, 0);
    cyc("ill0_dec", O_NONE);
    ifc.start = 1'b1;
    cyc("ill0_halt", O_HALT_ILL);
    cyc("ill0_halt2", O_HALT_ILL);
    ifc.start = 1'b0;
    check_val("ill0_instret", ifc.instret, 32'd6);

    do_reset();
    #1;
    check_val("rst2_outs", {20'd0, outs_now()}, 32'd0);
    check_val("rst2_instret", ifc.instret, 32'd0);

    // ecall halts without the illegal flag and without retiring
    start_pulse();
    do_fetch("ecall", 32'h0000_0073, 0);
    cyc("ecall_dec", O_NONE);
    cyc("ecall_exe", O_NONE);
    cyc("ecall_halt", O_HALT_SYS);
    check_val("ecall_instret", ifc.instret, 32'd0);

    // low bits not 11, and an unlisted opcode (fence)
    run_illegal("lowbits", 32'h0050_0092);
    run_illegal("fence", 32'h0000_000F);

    // rst while waiting on imem; a late ack must not load IR
    do_reset();
    start_pulse();
    cyc("rstf_fetch", O_FETCH);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ifc.inst     = 32'h0050_0093;
    ifc.imem_ack = 1'b1;
    cyc("rstf_idle", O_NONE);
    cyc("rstf_idle2", O_NONE);
    ifc.imem_ack = 1'b0;
    check_val("rstf_ir", u_dut.ir_q, 32'd0);

    // instret wrap, retiring addi x0,x0,0 (rd = x0 so no rf write)
    do_reset();
    force u_dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release u_dut.instret_q;
    #1;
    check_val("wrap_preload", ifc.instret, 32'hFFFF_FFFF);
    start_pulse();
    do_fetch("wrap", 32'h0000_0013, 0);
    cyc("wrap_dec", O_NONE);
    cyc("wrap_exe", O_NONE);
    cyc("wrap_wb", O_WB_X0);
    check_val("wrap_instret", ifc.instret, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
